// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs a req/ack handshake to instruction
// memory and hands one instruction at a time to the single-cycle datapath.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instruction,
  output logic [31:0]      currentInst,
  output logic             inst_valid,
  input  logic             inst_accept,
  input  logic [31:0]      programCounter,
  output logic [31:0]      pc,
  output logic             fetch_err,
  output logic [CNT_W-1:0] retired_count
);

  typedef enum logic [1:0] {BOOT, REQ, ISSUE, ERR} state_t;

  state_t state, stateNext;
  logic   loadInst;
  logic   retire;
  logic   pcAligned;

  assign pcAligned = (programCounter[1:0] == 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= BOOT;
    else     state <= stateNext;
  end

  // BOOT spends one idle cycle so an ack for a request killed by reset is dropped
  always_comb begin
    stateNext = state;
    imem_req  = 1'b0;
    loadInst  = 1'b0;
    retire    = 1'b0;
    unique case (state)
      BOOT:  stateNext = REQ;
      REQ: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          loadInst  = 1'b1;
          stateNext = ISSUE;
        end
      end
      ISSUE: begin
        if (inst_accept) begin
          retire    = 1'b1;
          stateNext = pcAligned ? REQ : ERR;
        end
      end
      ERR:   stateNext = ERR;
      default: stateNext = BOOT;
    endcase
  end

  assign imem_addr = imem_req ? pc : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc            <= RESET_PC;
      instruction   <= '0;
      currentInst   <= '0;
      inst_valid    <= 1'b0;
      fetch_err     <= 1'b0;
      retired_count <= '0;
    end else begin
      if (loadInst) begin
        instruction <= imem_rdata;
        currentInst <= pc + 32'd4;
        inst_valid  <= 1'b1;
      end
      if (retire) begin
        retired_count <= retired_count + CNT_W'(1);
        inst_valid    <= 1'b0;
        if (pcAligned) pc <= programCounter;
        else           fetch_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized bench for if_fetch_unit against a transaction-level fetch model.
module tb_if_fetch_unit;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          imem_req;
  logic [31:0]   imem_addr;
  logic          imem_ack = 1'b0;
  logic [31:0]   imem_rdata = '0;
  logic [31:0]   instruction;
  logic [31:0]   currentInst;
  logic          inst_valid;
  logic          inst_accept = 1'b0;
  logic [31:0]   programCounter = '0;
  logic [31:0]   pc;
  logic          fetch_err;
  logic [CW-1:0] retired_count;

  if_fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instruction(instruction), .currentInst(currentInst),
    .inst_valid(inst_valid), .inst_accept(inst_accept),
    .programCounter(programCounter), .pc(pc),
    .fetch_err(fetch_err), .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // model: 0 = idle after reset, 1 = fetching, 2 = instruction held, 3 = dead
  int          mMode;
  logic [31:0] mPc, mInst, mNext;
  bit          mValid, mErr;
  int unsigned mCount;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    mMode = 0; mPc = 32'h0; mInst = '0; mNext = '0;
    mValid = 0; mErr = 0; mCount = 0;
  endtask

  task automatic checkAll();
    logic req;
    req = (mMode == 1);
    checkVal("imem_req",    32'(imem_req), 32'(req));
    checkVal("imem_addr",   imem_addr, req ? mPc : 32'h0);
    checkVal("instruction", instruction, mInst);
    checkVal("currentInst", currentInst, mNext);
    checkVal("inst_valid",  32'(inst_valid), 32'(mValid));
    checkVal("pc",          pc, mPc);
    checkVal("fetch_err",   32'(fetch_err), 32'(mErr));
    checkVal("retired",     32'(retired_count), mCount % (1 << CW));
  endtask

  task automatic step(input bit ack, input logic [31:0] rd, input bit acc, input logic [31:0] npc);
    imem_ack = ack; imem_rdata = rd; inst_accept = acc; programCounter = npc;
    case (mMode)
      0: mMode = 1;
      1: if (ack) begin
           mInst = rd; mNext = mPc + 32'd4; mValid = 1; mMode = 2;
         end
      2: if (acc) begin
           mCount++; mValid = 0;
           if (npc % 4 == 0) begin mPc = npc; mMode = 1; end
           else begin mErr = 1; mMode = 3; end
         end
      default: ;
    endcase
    @(negedge clk);
    checkAll();
  endtask

  task automatic doReset(input bit lateAck);
    rst = 1'b1; imem_ack = lateAck;
    modelReset();
    #1 checkAll();
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [31:0] randPc();
    int unsigned r;
    r = $urandom_range(0, 19);
    if (r == 0)      return ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3));
    else if (r == 1) return 32'hFFFF_FFFC;
    else             return $urandom & 32'h0000_FFFC;
  endfunction

  initial begin
    modelReset();
    @(negedge clk);
    checkAll();
    rst = 1'b0;

    // boot, then same-cycle ack at RESET_PC
    step(0, 0, 0, 0);
    checkVal("firstReq", 32'(imem_req), 32'h1);
    step(1, 32'h2008_0005, 0, 0);
    checkVal("firstInst", instruction, 32'h2008_0005);
    checkVal("firstNext", currentInst, 32'h4);

    // go to 0x40, ack delayed three cycles
    step(0, 0, 1, 32'h40);
    for (int i = 0; i < 3; i++) step(0, $urandom, 0, 0);
    checkVal("delayedAddr", imem_addr, 32'h40);
    step(1, 32'hDEAD_BEEF, 0, 0);

    // hold with stray acks, then accept 0x100
    for (int i = 0; i < 5; i++) step(1, $urandom, 0, 32'h100);
    checkVal("heldInst", instruction, 32'hDEAD_BEEF);
    step(0, 0, 1, 32'h100);
    checkVal("pcAfterAccept", pc, 32'h100);
    checkVal("countAfterAccept", 32'(retired_count), 32'h2);

    // wrap of PC+4
    step(1, 32'h1111_1111, 0, 0);
    step(0, 0, 1, 32'hFFFF_FFFC);
    step(1, 32'h2222_2222, 0, 0);
    checkVal("wrapNext", currentInst, 32'h0);
    step(0, 0, 1, 32'h0);
    checkVal("wrapAddr", imem_addr, 32'h0);

    // misaligned next PC kills the fetch stream
    step(1, 32'h3333_3333, 0, 0);
    step(0, 0, 1, 32'h102);
    for (int i = 0; i < 4; i++) step(1, $urandom, 1, 32'h200);
    checkVal("errSticky", 32'(fetch_err), 32'h1);
    checkVal("errPc", pc, 32'h0);

    // reset while waiting on ack, late ack lands during the idle cycle
    doReset(1'b0);
    step(0, 0, 0, 0);
    step(1, 32'h4444_4444, 0, 0);
    step(0, 0, 1, 32'h80);
    step(0, 0, 0, 0);
    doReset(1'b1);
    step(1, 32'h5555_5555, 0, 0);
    checkVal("postResetAddr", imem_addr, 32'h0);
    checkVal("postResetValid", 32'(inst_valid), 32'h0);

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      if (mMode == 3 || $urandom_range(0, 199) == 0)
        doReset(1'($urandom_range(0, 1)));
      else
        step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), randPc());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
